// File: rtl/main_if.sv
// Trace/counter bundle between a memory-trace source and the cache hit/miss simulator.
interface main_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 16
);
    logic [ADDR_W-1:0] memory_trace;
    logic [CNT_W-1:0]  cache_hit;
    logic [CNT_W-1:0]  cache_miss;

    modport master (
        output memory_trace,
        input  cache_hit,
        input  cache_miss
    );

    modport slave (
        input  memory_trace,
        output cache_hit,
        output cache_miss
    );
endinterface

// File: rtl/main.sv
// Direct-mapped cache hit/miss simulator: tracks tag/valid per line and counts
// hits and misses over a stream of trace addresses. Only tags are stored.
module main #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned OFFSET_BITS = 3,
    parameter int unsigned INDEX_BITS  = 2,
    parameter int unsigned CNT_W       = 16
) (
    input logic   clk,
    input logic   rst_n,
    main_if.slave bus
);
    localparam int unsigned TagW  = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned Lines = 1 << INDEX_BITS;

    logic [Lines-1:0]  valid_q;
    logic [TagW-1:0]   tag_q [Lines];
    logic              first_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [INDEX_BITS-1:0] index;
    logic [TagW-1:0]       tag;
    logic                  access;
    logic                  hit;
    logic                  alloc;

    always_comb begin
        index      = bus.memory_trace[OFFSET_BITS +: INDEX_BITS];
        tag        = bus.memory_trace[ADDR_W-1 -: TagW];
        // A held address is a single access; only a change (or the first edge) counts.
        access     = first_q || (bus.memory_trace != last_addr_q);
        hit        = valid_q[index] && (tag_q[index] == tag);
        alloc      = access && !hit;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (access) begin
            if (hit) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            end
        end
    end

    // Tag/valid store: synchronous write on a miss, cleared wholesale by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < Lines; i++) begin
                tag_q[i] <= '0;
            end
        end else if (alloc) begin
            valid_q[index] <= 1'b1;
            tag_q[index]   <= tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q     <= 1'b1;
            last_addr_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            if (access) begin
                first_q     <= 1'b0;
                last_addr_q <= bus.memory_trace;
            end
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.cache_hit  = hit_cnt_q;
    assign bus.cache_miss = miss_cnt_q;
endmodule

// File: tb/tb_main.sv
// Scoreboard bench for the cache hit/miss simulator: a behavioural model predicts
// the counters after every edge, and a monitor compares them one edge later.
module tb_main;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    main_if bus ();

    main dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int hit;
        int miss;
    } exp_t;

    exp_t exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: cache described as plain arrays and integer arithmetic.
    bit m_valid[4];
    int m_tag[4];
    bit m_first;
    int m_last;
    int m_hit;
    int m_miss;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
        end
        m_first = 1'b1;
        m_last  = 0;
        m_hit   = 0;
        m_miss  = 0;
    endfunction

    function automatic void model_edge(input int a);
        int line;
        int tg;
        if (m_first || a != m_last) begin
            m_first = 1'b0;
            m_last  = a;
            line    = (a / 8) % 4;
            tg      = a / 32;
            if (m_valid[line] && m_tag[line] == tg) begin
                if (m_hit < 65535) m_hit++;
            end else begin
                if (m_miss < 65535) m_miss++;
                m_valid[line] = 1'b1;
                m_tag[line]   = tg;
            end
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counters of each edge are checked just after it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("edge_hit", int'(bus.cache_hit), e.hit);
            chk("edge_miss", int'(bus.cache_miss), e.miss);
        end
    end

    task automatic step(input int a);
        exp_t e;
        @(negedge clk);
        bus.memory_trace = a[15:0];
        if (rst_n) begin
            model_edge(a);
            e.hit  = m_hit;
            e.miss = m_miss;
            exp_q.push_back(e);
        end
    endtask

    task automatic hold(input int a, input int n);
        repeat (n) step(a);
    endtask

    task automatic release_with(input int a);
        exp_t e;
        @(negedge clk);
        bus.memory_trace = a[15:0];
        rst_n = 1'b1;
        model_edge(a);
        e.hit  = m_hit;
        e.miss = m_miss;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Reset asserted between edges must clear the counters without a clock.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_hit", int'(bus.cache_hit), 0);
        chk("async_rst_miss", int'(bus.cache_miss), 0);
        hold(int'($urandom_range(0, 255)), 2);
    endtask

    task automatic check_counts(input string name, input int h, input int m);
        settle();
        chk({name, "_hit"}, int'(bus.cache_hit), h);
        chk({name, "_miss"}, int'(bus.cache_miss), m);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int trace[12] = '{0, 9, 8, 1, 4, 5, 10, 4, 12, 16, 13, 18};
        int a;

        model_reset();
        bus.memory_trace = 16'h1234;
        repeat (3) @(negedge clk);
        chk("reset_hit", int'(bus.cache_hit), 0);
        chk("reset_miss", int'(bus.cache_miss), 0);

        // First access after reset, then same-block reuse and the full trace.
        release_with(0);
        check_counts("first_access", 0, 1);
        hold(0, 8);
        for (int i = 1; i < 4; i++) hold(trace[i], 10);
        check_counts("reuse", 2, 2);
        for (int i = 4; i < 12; i++) hold(trace[i], 10);
        check_counts("full_trace", 9, 3);

        // Conflict eviction on line 0.
        async_reset();
        release_with(0);
        hold(0, 9);
        hold(32, 10);
        hold(0, 10);
        check_counts("conflict", 0, 3);

        // Reset mid-run drops valid bits: replaying 0 misses again.
        async_reset();
        release_with(0);
        hold(0, 9);
        check_counts("replay", 0, 1);

        // Long hold is a single access.
        async_reset();
        release_with(8);
        hold(8, 49);
        check_counts("hold", 0, 1);

        // Randomized trace over a few tags per line, with variable hold lengths.
        async_reset();
        release_with(int'($urandom_range(0, 255)));
        for (int i = 0; i < 300; i++) begin
            a = int'($urandom_range(0, 255));
            hold(a, int'($urandom_range(1, 3)));
        end
        settle();
        chk("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
